// File: rtl/ulpi_reg_ctrl.sv
// ULPI register access controller: writes two PHY init registers after reset,
// then serves single register reads/writes from a simple request/ack port.
module ulpi_reg_ctrl #(
    parameter logic [7:0] FUNC_CTRL_INIT = 8'h48,
    parameter logic [7:0] OTG_CTRL_INIT  = 8'h00
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] ulpi_data_i,
    output logic [7:0] ulpi_data_o,
    input  logic       ulpi_dir_i,
    input  logic       ulpi_nxt_i,
    output logic       ulpi_stp_o,
    input  logic       reg_req_i,
    input  logic       reg_we_i,
    input  logic [5:0] reg_addr_i,
    input  logic [7:0] reg_wdata_i,
    output logic       reg_ack_o,
    output logic [7:0] reg_rdata_o,
    output logic       reg_err_o,
    output logic       init_done_o
);

    typedef enum logic [2:0] {
        S_INIT_FC, S_INIT_OTG, S_IDLE, S_CMD, S_WDATA, S_STP, S_RTURN, S_RDATA
    } state_t;

    state_t     state, state_next, origin;
    logic [5:0] addr_q;
    logic       we_q;
    logic [7:0] wdata_q;
    logic       launch, abort, done, capture;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_INIT_FC;
        else       state <= state_next;
    end

    // The cycle right after an ack is held off so the still-asserted request is not re-taken.
    always_comb begin
        state_next  = state;
        ulpi_data_o = 8'h00;
        ulpi_stp_o  = 1'b0;
        launch      = 1'b0;
        abort       = 1'b0;
        done        = 1'b0;
        capture     = 1'b0;
        case (state)
            S_INIT_FC, S_INIT_OTG: begin
                if (!ulpi_dir_i) begin
                    launch     = 1'b1;
                    state_next = S_CMD;
                end
            end
            S_IDLE: begin
                if (!ulpi_dir_i && reg_req_i && !reg_ack_o) begin
                    launch     = 1'b1;
                    state_next = S_CMD;
                end
            end
            S_CMD: begin
                if (ulpi_dir_i) begin
                    abort      = 1'b1;
                    state_next = origin;
                end else begin
                    ulpi_data_o = {1'b1, ~we_q, addr_q};
                    if (ulpi_nxt_i) state_next = we_q ? S_WDATA : S_RTURN;
                end
            end
            S_WDATA: begin
                if (ulpi_dir_i) begin
                    abort      = 1'b1;
                    state_next = origin;
                end else begin
                    ulpi_data_o = wdata_q;
                    if (ulpi_nxt_i) state_next = S_STP;
                end
            end
            S_STP: begin
                ulpi_stp_o = 1'b1;
                done       = 1'b1;
                state_next = (origin == S_INIT_FC) ? S_INIT_OTG : S_IDLE;
            end
            S_RTURN: begin
                if (ulpi_dir_i) begin
                    state_next = S_RDATA;
                end else begin
                    abort      = 1'b1;
                    state_next = origin;
                end
            end
            S_RDATA: begin
                capture    = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_INIT_FC;
        endcase
    end

    // Only accesses launched from IDLE belong to the user; init accesses never ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            origin      <= S_INIT_FC;
            addr_q      <= 6'h00;
            we_q        <= 1'b0;
            wdata_q     <= 8'h00;
            reg_ack_o   <= 1'b0;
            reg_err_o   <= 1'b0;
            reg_rdata_o <= 8'h00;
            init_done_o <= 1'b0;
        end else begin
            reg_ack_o <= 1'b0;
            reg_err_o <= 1'b0;
            if (launch) begin
                origin <= state;
                case (state)
                    S_INIT_FC: begin
                        addr_q  <= 6'h04;
                        we_q    <= 1'b1;
                        wdata_q <= FUNC_CTRL_INIT;
                    end
                    S_INIT_OTG: begin
                        addr_q  <= 6'h0A;
                        we_q    <= 1'b1;
                        wdata_q <= OTG_CTRL_INIT;
                    end
                    default: begin
                        addr_q  <= reg_addr_i;
                        we_q    <= reg_we_i;
                        wdata_q <= reg_wdata_i;
                    end
                endcase
            end
            if (abort && origin == S_IDLE) begin
                reg_ack_o <= 1'b1;
                reg_err_o <= 1'b1;
            end
            if (done && origin == S_IDLE) reg_ack_o <= 1'b1;
            if (capture) reg_rdata_o <= ulpi_data_i;
            if (done && origin == S_INIT_OTG) init_done_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ulpi_reg_ctrl.sv
// Directed + randomized bench for ulpi_reg_ctrl; a cycle-level PHY model drives
// the bus and expected bytes/acks are computed from the ULPI access rules.
module tb_ulpi_reg_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] ulpi_data_i;
    logic [7:0] ulpi_data_o;
    logic       ulpi_dir_i;
    logic       ulpi_nxt_i;
    logic       ulpi_stp_o;
    logic       reg_req_i;
    logic       reg_we_i;
    logic [5:0] reg_addr_i;
    logic [7:0] reg_wdata_i;
    logic       reg_ack_o;
    logic [7:0] reg_rdata_o;
    logic       reg_err_o;
    logic       init_done_o;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] model_rdata = 8'h00;

    ulpi_reg_ctrl #(.FUNC_CTRL_INIT(8'h48), .OTG_CTRL_INIT(8'h00)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ulpi_data_i(ulpi_data_i), .ulpi_data_o(ulpi_data_o),
        .ulpi_dir_i(ulpi_dir_i), .ulpi_nxt_i(ulpi_nxt_i), .ulpi_stp_o(ulpi_stp_o),
        .reg_req_i(reg_req_i), .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i),
        .reg_wdata_i(reg_wdata_i), .reg_ack_o(reg_ack_o), .reg_rdata_o(reg_rdata_o),
        .reg_err_o(reg_err_o), .init_done_o(init_done_o)
    );

    always #8 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkCycle(input string tag, input logic [7:0] exp_data, input logic exp_stp);
        checkOutput({tag, "_data"}, ulpi_data_o, exp_data);
        checkOutput({tag, "_stp"}, {7'd0, ulpi_stp_o}, {7'd0, exp_stp});
        checkOutput({tag, "_ack"}, {7'd0, reg_ack_o}, 8'h00);
    endtask

    task automatic applyStimulus(input logic req, input logic we, input logic [5:0] addr, input logic [7:0] wdata);
        reg_req_i   = req;
        reg_we_i    = we;
        reg_addr_i  = addr;
        reg_wdata_i = wdata;
    endtask

    // Request inputs wiggle mid-transaction; the latched copy must be used.
    task automatic scramble;
        reg_we_i    = 1'($urandom);
        reg_addr_i  = 6'($urandom);
        reg_wdata_i = 8'($urandom);
    endtask

    task automatic waitAndLaunch(input string tag, input int pre, input bit user,
                                 input logic we, input logic [5:0] addr, input logic [7:0] wdata);
        for (int i = 0; i < pre; i++) begin
            ulpi_dir_i = 1'b1; ulpi_nxt_i = 1'b0; settle;
            checkCycle({tag, "_wait"}, 8'h00, 1'b0);
            tick;
        end
        ulpi_dir_i = 1'b0; ulpi_nxt_i = 1'b0;
        if (user) applyStimulus(1'b1, we, addr, wdata);
        settle;
        checkCycle({tag, "_launch"}, 8'h00, 1'b0);
        tick;
    endtask

    task automatic runWrite(input string tag, input logic [5:0] addr, input logic [7:0] data,
                            input int n1, input int n2, input int pre, input bit user);
        waitAndLaunch(tag, pre, user, 1'b1, addr, data);
        for (int i = 1; i <= n1; i++) begin
            ulpi_nxt_i = (i == n1); if (user) scramble; settle;
            checkCycle({tag, "_txcmd"}, 8'h80 | {2'b00, addr}, 1'b0);
            tick;
        end
        for (int j = 1; j <= n2; j++) begin
            ulpi_nxt_i = (j == n2); settle;
            checkCycle({tag, "_wdata"}, data, 1'b0);
            tick;
        end
        ulpi_nxt_i = 1'b0; settle;
        checkCycle({tag, "_stp"}, 8'h00, 1'b1);
        tick;
        if (user) begin
            settle;
            checkOutput({tag, "_ack"}, {7'd0, reg_ack_o}, 8'h01);
            checkOutput({tag, "_err"}, {7'd0, reg_err_o}, 8'h00);
            reg_req_i = 1'b0;
            tick;
        end
    endtask

    task automatic runRead(input string tag, input logic [5:0] addr, input logic [7:0] value,
                           input int n1, input int pre, input bit abort_rturn);
        waitAndLaunch(tag, pre, 1'b1, 1'b0, addr, 8'($urandom));
        for (int i = 1; i <= n1; i++) begin
            ulpi_nxt_i = (i == n1); scramble; settle;
            checkCycle({tag, "_txcmd"}, 8'hC0 | {2'b00, addr}, 1'b0);
            tick;
        end
        ulpi_nxt_i = 1'b0; ulpi_dir_i = !abort_rturn; ulpi_data_i = 8'($urandom); settle;
        checkCycle({tag, "_rturn"}, 8'h00, 1'b0);
        tick;
        if (!abort_rturn) begin
            ulpi_dir_i = 1'b1; ulpi_data_i = value; settle;
            checkCycle({tag, "_rdata"}, 8'h00, 1'b0);
            tick;
            model_rdata = value;
        end
        ulpi_dir_i = 1'b0; ulpi_data_i = 8'($urandom); settle;
        checkOutput({tag, "_ack"}, {7'd0, reg_ack_o}, 8'h01);
        checkOutput({tag, "_err"}, {7'd0, reg_err_o}, {7'd0, abort_rturn});
        checkOutput({tag, "_rdval"}, reg_rdata_o, model_rdata);
        reg_req_i = 1'b0;
        tick;
    endtask

    // dir rises at the k-th cycle of TXCMD (or of write data); leaves dir high.
    task automatic runWriteAbort(input string tag, input logic [5:0] addr, input logic [7:0] data,
                                 input bit user, input bit in_wdata, input int k);
        waitAndLaunch(tag, 0, user, 1'b1, addr, data);
        if (in_wdata) begin
            ulpi_nxt_i = 1'b1; settle;
            checkCycle({tag, "_txcmd"}, 8'h80 | {2'b00, addr}, 1'b0);
            tick;
        end
        for (int i = 1; i < k; i++) begin
            ulpi_nxt_i = 1'b0; settle;
            checkCycle({tag, "_hold"}, in_wdata ? data : (8'h80 | {2'b00, addr}), 1'b0);
            tick;
        end
        ulpi_nxt_i = 1'b0; ulpi_dir_i = 1'b1; settle;
        checkCycle({tag, "_abort"}, 8'h00, 1'b0);
        tick;
        settle;
        checkOutput({tag, "_ack"}, {7'd0, reg_ack_o}, {7'd0, user});
        checkOutput({tag, "_err"}, {7'd0, reg_err_o}, {7'd0, user});
        checkOutput({tag, "_after_stp"}, {7'd0, ulpi_stp_o}, 8'h00);
        checkOutput({tag, "_after_data"}, ulpi_data_o, 8'h00);
        checkOutput({tag, "_done"}, {7'd0, init_done_o}, {7'd0, user});
        if (user) reg_req_i = 1'b0;
        tick;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_data"}, ulpi_data_o, 8'h00);
        checkOutput({tag, "_stp"}, {7'd0, ulpi_stp_o}, 8'h00);
        checkOutput({tag, "_ack"}, {7'd0, reg_ack_o}, 8'h00);
        checkOutput({tag, "_err"}, {7'd0, reg_err_o}, 8'h00);
        checkOutput({tag, "_rdata"}, reg_rdata_o, 8'h00);
        checkOutput({tag, "_done"}, {7'd0, init_done_o}, 8'h00);
    endtask

    initial begin
        logic [5:0] a;
        logic [7:0] d;

        // Reset with a user write already pending: it must wait for init.
        rst_i = 1'b1; ulpi_dir_i = 1'b0; ulpi_nxt_i = 1'b0; ulpi_data_i = 8'h00;
        applyStimulus(1'b1, 1'b1, 6'h16, 8'hA5);
        tick; tick;
        settle;
        checkResetState("reset");
        rst_i = 1'b0;

        $display("[TB] init sequence");
        runWrite("init_fc", 6'h04, 8'h48, 1, 1, 0, 1'b0);
        checkOutput("init_mid_done", {7'd0, init_done_o}, 8'h00);
        runWrite("init_otg", 6'h0A, 8'h00, 1, 1, 0, 1'b0);
        checkOutput("init_done", {7'd0, init_done_o}, 8'h01);

        $display("[TB] directed user accesses");
        runWrite("wr16", 6'h16, 8'hA5, 3, 1, 2, 1'b1);
        runRead("rd00", 6'h00, 8'h24, 1, 0, 1'b0);
        runWriteAbort("wr_abort_cmd", 6'h15, 8'h3C, 1'b1, 1'b0, 2);
        runWrite("wr_after_abort", 6'h15, 8'h3C, 1, 2, 1, 1'b1);
        runRead("rd_abort_rturn", 6'h2A, 8'hEE, 2, 0, 1'b1);
        runWriteAbort("wr_abort_wdata", 6'h07, 8'h5A, 1'b1, 1'b1, 1);
        runRead("rd_after_abort", 6'h07, 8'h81, 1, 1, 1'b0);

        $display("[TB] randomized accesses");
        for (int t = 0; t < 24; t++) begin
            a = 6'($urandom);
            d = 8'($urandom);
            case ($urandom_range(0, 3))
                0: runWrite("rnd_wr", a, d, $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(0, 2), 1'b1);
                1: runRead("rnd_rd", a, d, $urandom_range(1, 4), $urandom_range(0, 2), 1'b0);
                2: runWriteAbort("rnd_wr_abort", a, d, 1'b1, 1'($urandom), $urandom_range(1, 3));
                default: runRead("rnd_rd_abort", a, d, $urandom_range(1, 4), $urandom_range(0, 2), 1'b1);
            endcase
        end

        $display("[TB] reset during write data");
        waitAndLaunch("rst_wr", 0, 1'b1, 1'b1, 6'h11, 8'hC3);
        ulpi_nxt_i = 1'b1; settle;
        checkCycle("rst_wr_txcmd", 8'h91, 1'b0);
        tick;
        ulpi_nxt_i = 1'b0; rst_i = 1'b1; settle;
        checkCycle("rst_wr_wdata", 8'hC3, 1'b0);
        tick;
        settle;
        checkResetState("rst_wr_after");
        model_rdata = 8'h00;
        rst_i = 1'b0; reg_req_i = 1'b0;

        runWrite("reinit_fc", 6'h04, 8'h48, 2, 1, 1, 1'b0);
        runWriteAbort("reinit_otg_abort", 6'h0A, 8'h00, 1'b0, 1'b0, 1);
        checkOutput("reinit_wait_done", {7'd0, init_done_o}, 8'h00);
        runWrite("reinit_otg", 6'h0A, 8'h00, 1, 3, 2, 1'b0);
        checkOutput("reinit_done", {7'd0, init_done_o}, 8'h01);
        runRead("rd_after_reinit", 6'h01, 8'h5F, 1, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ulpi_reg_ctrl.md
ULPI_REG_CTRL -- requirements
Module: ulpi_reg_ctrl

Interface
REQ-001 Parameter FUNC_CTRL_INIT, 8'h48, value written to ULPI Function Control (addr 6'h04) after reset (SuspendM=1, OpMode=01 non-driving, HS).
REQ-002 Parameter OTG_CTRL_INIT, 8'h00, value written to ULPI OTG Control (addr 6'h0A) after reset (no pulldowns).
REQ-003 clk_i  in  1  ULPI 60 MHz clock; single clock domain.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 ulpi_data_i  in  8  data from ULPI bus.
REQ-006 ulpi_data_o  out  8  data to ULPI bus; IO buffers are enabled externally when ulpi_dir_i=0.
REQ-007 ulpi_dir_i  in  1  PHY owns the bus when 1.
REQ-008 ulpi_nxt_i  in  1  PHY throttle/accept.
REQ-009 ulpi_stp_o  out  1  link stop.
REQ-010 reg_req_i  in  1  register access request; held until reg_ack_o.
REQ-011 reg_we_i  in  1  1=write, 0=read.
REQ-012 reg_addr_i  in  6  ULPI register address.
REQ-013 reg_wdata_i  in  8  write data.
REQ-014 reg_ack_o  out  1  one-cycle completion pulse.
REQ-015 reg_rdata_o  out  8  read data, valid with reg_ack_o, held until next ack.
REQ-016 reg_err_o  out  1  with reg_ack_o: access aborted by PHY.
REQ-017 init_done_o  out  1  high once both init writes complete; stays high until reset.

Function
REQ-018 States: INIT_FC, INIT_OTG, IDLE, CMD, WDATA, STP, RTURN, RDATA.
REQ-019 A transaction is started from INIT_FC/INIT_OTG/IDLE only when ulpi_dir_i=0; while ulpi_dir_i=1, the controller waits and drives ulpi_data_o=0.
REQ-020 CMD: drive TXCMD = {2'b10,addr} for write, {2'b11,addr} for read; hold until ulpi_nxt_i=1.
REQ-021 Write: on nxt in CMD -> WDATA driving data; on nxt in WDATA -> STP; STP drives ulpi_stp_o=1 and ulpi_data_o=0 for exactly one cycle, then completion.
REQ-022 Read: on nxt in CMD -> RTURN; RTURN expects ulpi_dir_i=1 (turnaround cycle, data ignored) -> RDATA; RDATA captures ulpi_data_i into reg_rdata_o and completes.
REQ-023 Abort: ulpi_dir_i=1 while in CMD or WDATA (before the accepting nxt) -> return to originating state, ulpi_data_o=0, no stp; user access completes with reg_ack_o=1, reg_err_o=1; init accesses retry silently.
REQ-024 Abort in RTURN: ulpi_dir_i=0 -> user read acks with reg_err_o=1, reg_rdata_o unchanged.
REQ-025 Completion of user access: reg_ack_o pulses one cycle in the cycle after STP (write) or the cycle after RDATA (read); the next request is not sampled until the cycle after ack.
REQ-026 Init sequence: INIT_FC write, then INIT_OTG write, then IDLE with init_done_o=1; reg_req_i is ignored (no ack) until init_done_o=1.
REQ-027 ulpi_data_o=0 and ulpi_stp_o=0 in every state other than CMD, WDATA and STP.
REQ-028 Request inputs are latched when leaving IDLE; changes during a transaction have no effect.
REQ-029 No timeout: CMD waits indefinitely for nxt or dir.

Reset
REQ-030 rst_i=1 at a clock edge -> state INIT_FC, ulpi_data_o=0, ulpi_stp_o=0, reg_ack_o=0, reg_err_o=0, reg_rdata_o=0, init_done_o=0; applies mid-transaction, and no ack is issued for an access cut off by reset.
REQ-031 After reset release, the init sequence restarts from Function Control.

Verification
REQ-032 Reset, dir=0, PHY asserts nxt one cycle after each TXCMD/data -> bus shows 8'h84, 8'h48, stp pulse, 8'h8A, 8'h00, stp pulse; init_done_o=1.
REQ-033 Write addr 6'h16 data 8'hA5, nxt delayed 3 cycles -> 8'h96 held 3 cycles, then 8'hA5, stp one cycle, reg_ack_o=1, reg_err_o=0.
REQ-034 Read addr 6'h00, PHY: nxt, dir=1 turnaround, data 8'h24 -> reg_rdata_o=8'h24, reg_ack_o=1, reg_err_o=0.
REQ-035 dir rises during CMD of a user write -> data_o=0, no stp, reg_ack_o=1 with reg_err_o=1; next request proceeds normally.
REQ-036 dir rises during INIT_OTG CMD -> retried after dir falls; init_done_o only after the successful write.
REQ-037 rst_i asserted in WDATA -> next cycle data_o=0, stp_o=0, no ack; init sequence reruns.
